// File: rtl/detector_jogada_pkg.sv
// rtl/detector_jogada_pkg.sv - shared FSM encodings, button count and one-hot check
//   No ports; imported by detector_jogada and by the downstream control unit.
package detector_jogada_pkg;

    localparam int NUM_BOTOES = 4;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        ARMADO    = 3'd1,
        DEBOUNCE  = 3'd2,
        REGISTRA  = 3'd3,
        INVALIDA  = 3'd4,
        SOLTURA   = 3'd5,
        TEMPO     = 3'd6,
        BLOQUEADO = 3'd7
    } estado_t;

    // True when exactly one button is set; zero or several presses are not a move.
    function automatic logic eh_one_hot(input logic [NUM_BOTOES-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_BOTOES; i++) begin
            n = n + int'(v[i]);
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/sincronizador_botoes.sv
// rtl/sincronizador_botoes.sv - parameterised-width 2-flop synchroniser
//   clock  : system clock
//   reset  : asynchronous active-high clear
//   d      : asynchronous input levels
//   q      : levels synchronised to clock
module sincronizador_botoes #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - debounced single-button move capture with turn timeout
//   clock           : system clock, rising edge
//   reset           : asynchronous active-high clear
//   botoes          : raw button levels, 1 = pressed
//   habilita        : capture enabled for the current turn
//   limpa           : synchronous clear of jogada
//   jogada          : last accepted one-hot press
//   jogada_feita    : one-cycle pulse, jogada just updated
//   jogada_invalida : one-cycle pulse, debounced candidate was not one-hot
//   timeout         : one-cycle pulse, turn timed out
module detector_jogada
    import detector_jogada_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int TIMEOUT_CICLOS  = 20
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_BOTOES-1:0] botoes,
    input  logic                  habilita,
    input  logic                  limpa,
    output logic [NUM_BOTOES-1:0] jogada,
    output logic                  jogada_feita,
    output logic                  jogada_invalida,
    output logic                  timeout
);

    localparam int TW = $clog2(TIMEOUT_CICLOS);
    localparam int DW = $clog2(DEBOUNCE_CICLOS) + 1;
    localparam logic [TW-1:0] TEMPO_MAX = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CICLOS - 1);

    logic [NUM_BOTOES-1:0] sinc;
    logic [NUM_BOTOES-1:0] candidato;
    logic [TW-1:0]         cnt_tempo;
    logic [DW-1:0]         cnt_deb;
    estado_t               estado, proximo;

    sincronizador_botoes #(.WIDTH(NUM_BOTOES)) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (botoes),
        .q     (sinc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        unique case (estado)
            OCIOSO: begin
                if (habilita) begin
                    proximo = (sinc == '0) ? ARMADO : SOLTURA;
                end
            end
            ARMADO: begin
                // A fresh press outranks a timeout landing on the same cycle.
                if (!habilita)                proximo = OCIOSO;
                else if (sinc != '0)          proximo = DEBOUNCE;
                else if (cnt_tempo == TEMPO_MAX) proximo = TEMPO;
            end
            DEBOUNCE: begin
                if (!habilita)                proximo = OCIOSO;
                else if (sinc != candidato)   proximo = ARMADO;
                else if (cnt_deb == DEB_MAX)  proximo = eh_one_hot(candidato) ? REGISTRA : INVALIDA;
            end
            // Pulse states ignore habilita so a pulse is never cut short.
            REGISTRA:  proximo = SOLTURA;
            INVALIDA:  proximo = SOLTURA;
            SOLTURA: begin
                if (!habilita)                proximo = OCIOSO;
                else if (sinc == '0)          proximo = ARMADO;
            end
            TEMPO:     proximo = BLOQUEADO;
            BLOQUEADO: begin
                if (!habilita)                proximo = OCIOSO;
            end
            default:   proximo = OCIOSO;
        endcase
    end

    // Turn timer: restarts only when a turn (re)arms; a bounce back from
    // DEBOUNCE keeps the time already spent. Saturates instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_tempo <= '0;
        end else if (proximo == ARMADO && (estado == OCIOSO || estado == SOLTURA)) begin
            cnt_tempo <= '0;
        end else if (estado == ARMADO && cnt_tempo != TEMPO_MAX) begin
            cnt_tempo <= cnt_tempo + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_deb   <= '0;
            candidato <= '0;
        end else if (estado == ARMADO && proximo == DEBOUNCE) begin
            cnt_deb   <= '0;
            candidato <= sinc;
        end else if (estado == DEBOUNCE && proximo == DEBOUNCE && cnt_deb != DEB_MAX) begin
            cnt_deb   <= cnt_deb + 1'b1;
        end
    end

    // The accept load happens on the edge entering REGISTRA and beats limpa.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            jogada <= '0;
        end else if (proximo == REGISTRA && estado != REGISTRA) begin
            jogada <= candidato;
        end else if (limpa && estado != REGISTRA) begin
            jogada <= '0;
        end
    end

    assign jogada_feita    = (estado == REGISTRA);
    assign jogada_invalida = (estado == INVALIDA);
    assign timeout         = (estado == TEMPO);

endmodule

// File: tb/tb_detector_jogada.sv
// tb/tb_detector_jogada.sv - scoreboard bench for detector_jogada
module tb_detector_jogada;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] botoes = 4'b0000;
    logic       habilita = 1'b0;
    logic       limpa = 1'b0;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       jogada_invalida;
    logic       timeout;

    int n_verif = 0;
    int n_falhas = 0;
    int ciclo = 0;

    // tipo: bit0 = feita, bit1 = invalida, bit2 = timeout
    typedef struct {
        logic [2:0] tipo;
        logic [3:0] jog;
        int         ciclo;
    } evento_t;

    evento_t fila[$];

    localparam logic [2:0] EV_FEITA = 3'b001;
    localparam logic [2:0] EV_INV   = 3'b010;
    localparam logic [2:0] EV_TEMPO = 3'b100;

    detector_jogada #(.DEBOUNCE_CICLOS(4), .TIMEOUT_CICLOS(20)) dut (
        .clock           (clock),
        .reset           (reset),
        .botoes          (botoes),
        .habilita        (habilita),
        .limpa           (limpa),
        .jogada          (jogada),
        .jogada_feita    (jogada_feita),
        .jogada_invalida (jogada_invalida),
        .timeout         (timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) ciclo <= ciclo + 1;

    task automatic verifica(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
        n_verif = n_verif + 1;
        if (obtido !== esperado) begin
            n_falhas = n_falhas + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, obtido, esperado, ciclo);
        end
    endtask

    task automatic passo(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic espera(input logic [2:0] tipo, input logic [3:0] jog, input int c);
        evento_t e;
        e.tipo = tipo;
        e.jog = jog;
        e.ciclo = c;
        fila.push_back(e);
    endtask

    // Monitor: every pulse the DUT raises must match the oldest expected event.
    always @(negedge clock) begin
        logic [2:0] obs;
        evento_t e;
        obs = {timeout, jogada_invalida, jogada_feita};
        if (!reset && obs != 3'b000) begin
            n_verif = n_verif + 1;
            if (fila.size() == 0) begin
                n_falhas = n_falhas + 1;
                $display("FAIL unexpected_pulse: got pulses %b jogada %b at cycle %0d, expected none", obs, jogada, ciclo);
            end else begin
                e = fila.pop_front();
                if (obs !== e.tipo || jogada !== e.jog || ciclo != e.ciclo) begin
                    n_falhas = n_falhas + 1;
                    $display("FAIL pulse_event: got pulses %b jogada %b cycle %0d, expected pulses %b jogada %b cycle %0d",
                             obs, jogada, ciclo, e.tipo, e.jog, e.ciclo);
                end
            end
        end
    end

    initial begin
        int k;

        // Reset state
        #12;
        verifica("reset_jogada", 32'(jogada), 32'h0);
        verifica("reset_pulses", 32'({timeout, jogada_invalida, jogada_feita}), 32'h0);
        passo(2);
        reset = 1'b0;
        habilita = 1'b1;
        passo(2);

        // Clean press 0100: accept 7 edges after press, single pulse while held
        k = ciclo;
        botoes = 4'b0100;
        espera(EV_FEITA, 4'b0100, k + 7);
        passo(10);
        verifica("press_0100", 32'(jogada), 32'h4);
        botoes = 4'b0000;
        passo(4);

        // Bounce then stable 0010
        botoes = 4'b0010;
        passo(2);
        botoes = 4'b0000;
        passo(3);
        k = ciclo;
        botoes = 4'b0010;
        espera(EV_FEITA, 4'b0010, k + 7);
        passo(10);
        verifica("bounce_0010", 32'(jogada), 32'h2);
        botoes = 4'b0000;
        passo(4);

        // Two buttons: invalid pulse, jogada unchanged
        k = ciclo;
        botoes = 4'b0110;
        espera(EV_INV, 4'b0010, k + 7);
        passo(10);
        verifica("invalid_keeps", 32'(jogada), 32'h2);

        // Release re-arms with the timer cleared; 20 idle armed cycles -> timeout
        k = ciclo;
        botoes = 4'b0000;
        espera(EV_TEMPO, 4'b0010, k + 23);
        passo(4);
        passo(25);
        verifica("timeout_queue_drained", 32'(fila.size()), 32'h0);

        // Press while blocked is ignored
        botoes = 4'b0001;
        passo(10);
        verifica("blocked_ignores", 32'(jogada), 32'h2);
        botoes = 4'b0000;
        habilita = 1'b0;
        passo(3);
        habilita = 1'b1;
        passo(2);

        // Asynchronous reset in the middle of debouncing 1000
        botoes = 4'b1000;
        passo(4);
        #2;
        reset = 1'b1;
        #1;
        verifica("async_reset_jogada", 32'(jogada), 32'h0);
        verifica("async_reset_pulses", 32'({timeout, jogada_invalida, jogada_feita}), 32'h0);
        habilita = 1'b0;
        botoes = 4'b0000;
        passo(2);
        reset = 1'b0;
        habilita = 1'b1;
        passo(3);
        k = ciclo;
        botoes = 4'b1000;
        espera(EV_FEITA, 4'b1000, k + 7);
        passo(10);
        verifica("after_reset_1000", 32'(jogada), 32'h8);
        botoes = 4'b0000;
        passo(4);

        // Accept 0001 then clear it with limpa
        k = ciclo;
        botoes = 4'b0001;
        espera(EV_FEITA, 4'b0001, k + 7);
        passo(10);
        botoes = 4'b0000;
        passo(4);
        verifica("press_0001", 32'(jogada), 32'h1);
        limpa = 1'b1;
        passo(1);
        limpa = 1'b0;
        verifica("limpa_clears", 32'(jogada), 32'h0);

        // Button already held when habilita rises: needs release and re-press
        habilita = 1'b0;
        passo(2);
        botoes = 4'b0100;
        passo(3);
        habilita = 1'b1;
        passo(12);
        verifica("held_no_accept", 32'(jogada), 32'h0);
        botoes = 4'b0000;
        passo(4);
        k = ciclo;
        botoes = 4'b0100;
        espera(EV_FEITA, 4'b0100, k + 7);
        passo(10);
        verifica("repress_0100", 32'(jogada), 32'h4);
        botoes = 4'b0000;
        passo(4);

        verifica("all_events_seen", 32'(fila.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_falhas);
        $finish;
    end

endmodule
